// File: rtl/aes_inv_main.sv
// Iterative AES-128 inverse cipher: on-chip key expansion (optionally cached),
// then one inverse round per clock with a start/done handshake.
module aes_inv_main #(
    parameter int unsigned KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    input  logic         decrypt_start,
    output logic [127:0] data_out,
    output logic         decrypt_done,
    output logic         busy
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {IDLE, KEYEXP, ARK, ROUND, FINAL} fsm_t;

    fsm_t             fsm;
    logic [BLK_W-1:0] blk_state;
    logic [BLK_W-1:0] rk [0:10];
    logic [CNT_W-1:0] cnt;
    logic             cache_valid;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] a;
        a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    // InvShiftRows followed by InvSubBytes; byte r+4c lives at [127-8(r+4c) -: 8]
    function automatic logic [BLK_W-1:0] inv_sub_shift(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] next_round_key(input logic [BLK_W-1:0] prev,
                                                        input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= IDLE;
            data_out     <= '0;
            decrypt_done <= 1'b0;
            busy         <= 1'b0;
            cache_valid  <= 1'b0;
            cnt          <= '0;
        end else begin
            decrypt_done <= 1'b0;
            case (fsm)
                IDLE: begin
                    busy <= 1'b0;
                    if (decrypt_start) begin
                        blk_state <= data_in;
                        rk[0]     <= key;
                        busy      <= 1'b1;
                        if ((KEY_CACHE != 0) && cache_valid && (key == rk[0])) begin
                            fsm <= ARK;
                        end else begin
                            // rk[1..10] are stale until this expansion completes
                            cache_valid <= 1'b0;
                            cnt         <= 4'd1;
                            fsm         <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    rk[cnt] <= next_round_key(rk[CNT_W'(cnt - 4'd1)], rcon(cnt));
                    if (cnt == 4'd10) begin
                        cache_valid <= 1'b1;
                        fsm         <= ARK;
                    end else begin
                        cnt <= CNT_W'(cnt + 4'd1);
                    end
                end
                ARK: begin
                    blk_state <= blk_state ^ rk[10];
                    cnt       <= 4'd9;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    blk_state <= inv_mix_columns(inv_sub_shift(blk_state) ^ rk[cnt]);
                    cnt       <= CNT_W'(cnt - 4'd1);
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    data_out     <= inv_sub_shift(blk_state) ^ rk[0];
                    decrypt_done <= 1'b1;
                    fsm          <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
